// File: rtl/fetch_decoder_pkg.sv
// rtl/fetch_decoder_pkg.sv - shared opcodes, flag positions, widths and FSM states
package fetch_decoder_pkg;

    localparam int WORD_W = 32;
    localparam int OFF_W  = 32;
    localparam int FLG_W  = 6;

    localparam logic [7:0] OP_MOV = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_CMP = 8'h03;
    localparam logic [7:0] OP_JMP = 8'h04;
    localparam logic [7:0] OP_JEQ = 8'h05;
    localparam logic [7:0] OP_JGG = 8'h06;
    localparam logic [7:0] OP_HLT = 8'hFF;

    localparam int FLG_MOV = 5;
    localparam int FLG_ADD = 4;
    localparam int FLG_CMP = 3;
    localparam int FLG_JMP = 2;
    localparam int FLG_JEQ = 1;
    localparam int FLG_JGG = 0;

    typedef enum logic [2:0] {
        RD0,
        RD1,
        RD2,
        RD3,
        ISSUE,
        HALT,
        ERROR
    } state_t;

endpackage

// File: rtl/fetch_decoder_opcode_decoder.sv
// rtl/fetch_decoder_opcode_decoder.sv - combinational opcode to one-hot command decode
// Ports:
//   op_i         opcode byte (word0[7:0])
//   flags_o      one-hot command flags, zero for HLT and illegal opcodes
//   is_hlt_o     opcode is HLT
//   is_illegal_o opcode is not a known command
module opcode_decoder
    import fetch_decoder_pkg::*;
(
    input  logic [7:0]       op_i,
    output logic [FLG_W-1:0] flags_o,
    output logic             is_hlt_o,
    output logic             is_illegal_o
);

    always_comb begin
        flags_o      = '0;
        is_hlt_o     = 1'b0;
        is_illegal_o = 1'b0;
        case (op_i)
            OP_MOV:  flags_o[FLG_MOV] = 1'b1;
            OP_ADD:  flags_o[FLG_ADD] = 1'b1;
            OP_CMP:  flags_o[FLG_CMP] = 1'b1;
            OP_JMP:  flags_o[FLG_JMP] = 1'b1;
            OP_JEQ:  flags_o[FLG_JEQ] = 1'b1;
            OP_JGG:  flags_o[FLG_JGG] = 1'b1;
            OP_HLT:  is_hlt_o         = 1'b1;
            default: is_illegal_o     = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decoder.sv
// rtl/fetch_decoder.sv - 3-word instruction fetch, decode and issue to the executor
// Ports:
//   CLK_, RST_          clock, asynchronous active-high reset
//   PMEM_ADDR_/DATA_    synchronous program memory read port (data one cycle after address)
//   EXEC_FL_            command valid; CMD_FLGS_ one-hot command, CMD_ARG_ {word2,word1,word0}
//   READY_FL_, JMP_FL_  executor done / take jump; NEW_EXEC_ADDR_OFF_ jump offset in words
//   PC_, INSTR_CNT_     current instruction address, retired instruction count
//   HALTED_, ERR_       sticky HLT reached / illegal opcode or handshake timeout
module fetch_decoder
    import fetch_decoder_pkg::*;
#(
    parameter int  PMEM_SIZE = 64,
    parameter int  RESET_PC  = 0,
    parameter int  TIMEOUT   = 15,
    localparam int AW        = $clog2(PMEM_SIZE)
) (
    input  logic                CLK_,
    input  logic                RST_,
    output logic [AW-1:0]       PMEM_ADDR_,
    input  logic [WORD_W-1:0]   PMEM_DATA_,
    output logic                EXEC_FL_,
    output logic [FLG_W-1:0]    CMD_FLGS_,
    output logic [3*WORD_W-1:0] CMD_ARG_,
    input  logic                READY_FL_,
    input  logic                JMP_FL_,
    input  logic [OFF_W-1:0]    NEW_EXEC_ADDR_OFF_,
    output logic [AW-1:0]       PC_,
    output logic [WORD_W-1:0]   INSTR_CNT_,
    output logic                HALTED_,
    output logic                ERR_
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT);
    localparam logic [AW-1:0] RESET_PC_C = AW'(RESET_PC);

    state_t                state_q;
    logic [AW-1:0]         pc_q;
    logic [TW-1:0]         tmo_q;
    logic                  exec_q;
    logic [FLG_W-1:0]      flgs_q;
    logic [3*WORD_W-1:0]   arg_q;
    logic [WORD_W-1:0]     cnt_q;
    logic                  halted_q;
    logic                  err_q;

    logic [FLG_W-1:0]      dec_flags;
    logic                  dec_hlt;
    logic                  dec_illegal;
    logic [AW-1:0]         pc_p1;
    logic [AW-1:0]         pc_p2;
    logic [AW-1:0]         pc_p3;
    logic [AW-1:0]         pc_jmp;
    logic                  unused_off;

    // word0 is already in arg_q[31:0] by the time RD3 decodes it
    opcode_decoder u_dec (
        .op_i         (arg_q[7:0]),
        .flags_o      (dec_flags),
        .is_hlt_o     (dec_hlt),
        .is_illegal_o (dec_illegal)
    );

    // PC arithmetic is truncated to AW bits so every fetch and jump wraps
    assign pc_p1      = pc_q + AW'(1);
    assign pc_p2      = pc_q + AW'(2);
    assign pc_p3      = pc_q + AW'(3);
    assign pc_jmp     = pc_q + NEW_EXEC_ADDR_OFF_[AW-1:0];
    assign unused_off = ^NEW_EXEC_ADDR_OFF_[OFF_W-1:AW];

    // Address stays at PC+2 after RD2, so it is held through ISSUE/HALT/ERROR
    always_comb begin
        case (state_q)
            RD0:     PMEM_ADDR_ = pc_q;
            RD1:     PMEM_ADDR_ = pc_p1;
            default: PMEM_ADDR_ = pc_p2;
        endcase
    end

    always_ff @(posedge CLK_ or posedge RST_) begin
        if (RST_) begin
            state_q  <= RD0;
            pc_q     <= RESET_PC_C;
            tmo_q    <= '0;
            exec_q   <= 1'b0;
            flgs_q   <= '0;
            arg_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                RD0: state_q <= RD1;
                RD1: begin
                    arg_q[WORD_W-1:0] <= PMEM_DATA_;
                    state_q           <= RD2;
                end
                RD2: begin
                    arg_q[2*WORD_W-1:WORD_W] <= PMEM_DATA_;
                    state_q                  <= RD3;
                end
                RD3: begin
                    arg_q[3*WORD_W-1:2*WORD_W] <= PMEM_DATA_;
                    if (dec_illegal) begin
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else if (dec_hlt) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        exec_q  <= 1'b1;
                        flgs_q  <= dec_flags;
                        tmo_q   <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // READY takes priority over a timeout expiring on the same edge
                    if (READY_FL_) begin
                        exec_q  <= 1'b0;
                        flgs_q  <= '0;
                        cnt_q   <= cnt_q + 32'd1;
                        tmo_q   <= '0;
                        pc_q    <= JMP_FL_ ? pc_jmp : pc_p3;
                        state_q <= RD0;
                    end else if (tmo_q + TW'(1) == TIMEOUT_C) begin
                        exec_q  <= 1'b0;
                        flgs_q  <= '0;
                        tmo_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                HALT:    state_q <= HALT;
                ERROR:   state_q <= ERROR;
                default: begin
                    err_q   <= 1'b1;
                    state_q <= ERROR;
                end
            endcase
        end
    end

    assign EXEC_FL_   = exec_q;
    assign CMD_FLGS_  = flgs_q;
    assign CMD_ARG_   = arg_q;
    assign PC_        = pc_q;
    assign INSTR_CNT_ = cnt_q;
    assign HALTED_    = halted_q;
    assign ERR_       = err_q;

endmodule

// File: tb/tb_fetch_decoder.sv
// tb/tb_fetch_decoder.sv - scoreboard bench for fetch_decoder
module tb_fetch_decoder;

    localparam int AW = 6;

    logic          CLK_ = 1'b0;
    logic          RST_ = 1'b0;
    logic [AW-1:0] PMEM_ADDR_;
    logic [31:0]   PMEM_DATA_ = 32'h0;
    logic          EXEC_FL_;
    logic [5:0]    CMD_FLGS_;
    logic [95:0]   CMD_ARG_;
    logic          READY_FL_ = 1'b0;
    logic          JMP_FL_ = 1'b0;
    logic [31:0]   NEW_EXEC_ADDR_OFF_ = 32'h0;
    logic [AW-1:0] PC_;
    logic [31:0]   INSTR_CNT_;
    logic          HALTED_;
    logic          ERR_;

    always #5 CLK_ = ~CLK_;

    fetch_decoder #(.PMEM_SIZE(64), .RESET_PC(0), .TIMEOUT(15)) dut (
        .CLK_               (CLK_),
        .RST_               (RST_),
        .PMEM_ADDR_         (PMEM_ADDR_),
        .PMEM_DATA_         (PMEM_DATA_),
        .EXEC_FL_           (EXEC_FL_),
        .CMD_FLGS_          (CMD_FLGS_),
        .CMD_ARG_           (CMD_ARG_),
        .READY_FL_          (READY_FL_),
        .JMP_FL_            (JMP_FL_),
        .NEW_EXEC_ADDR_OFF_ (NEW_EXEC_ADDR_OFF_),
        .PC_                (PC_),
        .INSTR_CNT_         (INSTR_CNT_),
        .HALTED_            (HALTED_),
        .ERR_               (ERR_)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Synchronous-read program memory; also records the addresses it was asked for
    logic [31:0]   mem [64];
    logic [AW-1:0] ahist [4];
    always @(posedge CLK_) begin
        PMEM_DATA_ <= mem[PMEM_ADDR_];
        ahist[3]   <= ahist[2];
        ahist[2]   <= ahist[1];
        ahist[1]   <= ahist[0];
        ahist[0]   <= PMEM_ADDR_;
    end

    // Executor model: READY pulse ready_delay negedges after issue (0 = never)
    int ready_delay = 2;
    bit take_jumps  = 1'b0;
    int ecyc        = 0;
    always @(negedge CLK_) begin
        if (EXEC_FL_ && !RST_) begin
            ecyc++;
            if (ecyc == ready_delay) begin
                READY_FL_          = 1'b1;
                JMP_FL_            = take_jumps && (|CMD_FLGS_[2:0]);
                NEW_EXEC_ADDR_OFF_ = CMD_ARG_[63:32];
            end else begin
                READY_FL_ = 1'b0;
                JMP_FL_   = 1'b0;
            end
        end else begin
            ecyc      = 0;
            READY_FL_ = 1'b0;
            JMP_FL_   = 1'b0;
        end
    end

    typedef struct {
        logic [5:0]    flg;
        logic [95:0]   arg;
        logic [AW-1:0] pc;
        logic [AW-1:0] a0, a1, a2;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    task automatic push(input logic [5:0] flg, input logic [95:0] arg, input logic [AW-1:0] pc,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        exp_t x;
        x.flg = flg; x.arg = arg; x.pc = pc; x.a0 = a0; x.a1 = a1; x.a2 = a2;
        exp_q.push_back(x);
    endtask

    // Monitor: pops one expectation on each rising EXEC_FL_
    logic exec_prev = 1'b0;
    int   hi_run    = 0;
    int   issues    = 0;
    int   viol      = 0;
    always @(negedge CLK_) begin
        if (!RST_) begin
            if (!EXEC_FL_ && CMD_FLGS_ != 6'b0) viol++;
            if (EXEC_FL_ && !exec_prev) begin
                issues++;
                hi_run = 1;
                if (exp_q.size() == 0) begin
                    chk("issue_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_flags", CMD_FLGS_, e.flg);
                    chk("issue_arg", CMD_ARG_, e.arg);
                    chk("issue_pc", PC_, e.pc);
                    chk("issue_fetch_addrs", {ahist[3], ahist[2], ahist[1]}, {e.a0, e.a1, e.a2});
                end
            end else if (EXEC_FL_) begin
                hi_run++;
            end
        end
        exec_prev = EXEC_FL_;
    end

    task automatic start_run(input int delay, input bit take);
        RST_ = 1'b1;
        repeat (2) @(negedge CLK_);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        ready_delay = delay;
        take_jumps  = take;
        exp_q.delete();
        issues = 0;
        hi_run = 0;
    endtask

    task automatic release_rst;
        @(negedge CLK_);
        #2 RST_ = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (!(HALTED_ || ERR_) && n < bound) begin
            @(negedge CLK_); #1;
            n++;
        end
        chk("run_terminates", HALTED_ | ERR_, 1);
    endtask

    task automatic wait_issues(input int k, input int bound);
        int n = 0;
        while (issues < k && n < bound) begin
            @(negedge CLK_); #1;
            n++;
        end
        chk("issue_count_reached", issues, k);
    endtask

    task automatic end_run;
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        // MOV then HLT; latency and reset state
        start_run(2, 1'b0);
        chk("reset_state", {PC_, EXEC_FL_, CMD_FLGS_, INSTR_CNT_, HALTED_, ERR_, PMEM_ADDR_}, 0);
        chk("reset_arg", CMD_ARG_, 0);
        mem[0] = 32'h0000_0101; mem[1] = 32'h1111_1111; mem[2] = 32'h2222_2222; mem[3] = 32'h0000_00FF;
        push(6'b100000, {32'h2222_2222, 32'h1111_1111, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        repeat (3) @(negedge CLK_);
        chk("t1_exec_low_after_3_edges", EXEC_FL_, 0);
        @(negedge CLK_);
        chk("t1_exec_high_after_4_edges", EXEC_FL_, 1);
        wait_end(60);
        chk("t1_final", {HALTED_, ERR_, PC_, INSTR_CNT_}, {1'b1, 1'b0, 6'd3, 32'd1});
        end_run;

        // MOV, CMP, taken JMP back to 0, MOV again
        start_run(2, 1'b1);
        mem[0] = 32'h0000_0101; mem[1] = 32'h0000_000A; mem[2] = 32'h0000_000B;
        mem[3] = 32'h00AB_CD03; mem[4] = 32'h0000_000C; mem[5] = 32'h0000_000D;
        mem[6] = 32'h0000_0004; mem[7] = 32'hFFFF_FFFA; mem[8] = 32'h0000_0006;
        push(6'b100000, {32'h0000_000B, 32'h0000_000A, 32'h0000_0101}, 0, 0, 1, 2);
        push(6'b001000, {32'h0000_000D, 32'h0000_000C, 32'h00AB_CD03}, 3, 3, 4, 5);
        push(6'b000100, {32'h0000_0006, 32'hFFFF_FFFA, 32'h0000_0004}, 6, 6, 7, 8);
        push(6'b100000, {32'h0000_000B, 32'h0000_000A, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        wait_issues(4, 200);
        chk("t2a_cnt_after_jump", INSTR_CNT_, 3);
        end_run;

        // Untaken JEQ at 6 falls through to HLT at 9
        start_run(2, 1'b0);
        mem[0] = 32'h0000_0101; mem[3] = 32'h00AB_CD03;
        mem[6] = 32'h0000_0005; mem[7] = 32'h0000_0010; mem[9] = 32'h0000_00FF;
        push(6'b100000, {32'h0, 32'h0, 32'h0000_0101}, 0, 0, 1, 2);
        push(6'b001000, {32'h0, 32'h0, 32'h00AB_CD03}, 3, 3, 4, 5);
        push(6'b000010, {32'h0, 32'h0000_0010, 32'h0000_0005}, 6, 6, 7, 8);
        release_rst;
        wait_end(100);
        chk("t2b_final", {HALTED_, ERR_, PC_, INSTR_CNT_}, {1'b1, 1'b0, 6'd9, 32'd3});
        end_run;

        // Illegal opcode 0x07
        start_run(2, 1'b0);
        mem[0] = 32'h0000_0007;
        release_rst;
        repeat (3) @(negedge CLK_);
        chk("t3_err_low_before_rd3", ERR_, 0);
        @(negedge CLK_);
        chk("t3_err_after_rd3", ERR_, 1);
        repeat (3) @(negedge CLK_);
        chk("t3_final", {HALTED_, ERR_, EXEC_FL_, CMD_FLGS_, PC_}, {1'b0, 1'b1, 1'b0, 6'b0, 6'd0});
        chk("t3_no_issue", issues, 0);
        end_run;

        // Handshake timeout: executor never answers
        start_run(0, 1'b0);
        mem[0] = 32'h0000_0101;
        push(6'b100000, {32'h0, 32'h0, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        wait_end(60);
        chk("t4a_final", {HALTED_, ERR_, EXEC_FL_, CMD_FLGS_, INSTR_CNT_}, {1'b0, 1'b1, 1'b0, 6'b0, 32'd0});
        chk("t4a_exec_high_cycles", hi_run, 15);
        end_run;

        // READY on the expiry edge wins
        start_run(15, 1'b0);
        mem[0] = 32'h0000_0101; mem[3] = 32'h0000_00FF;
        push(6'b100000, {32'h0, 32'h0, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        wait_end(80);
        chk("t4b_final", {HALTED_, ERR_, PC_, INSTR_CNT_}, {1'b1, 1'b0, 6'd3, 32'd1});
        chk("t4b_exec_high_cycles", hi_run, 15);
        end_run;

        // Jump to 62: fetch wraps 62, 63, 0; PC+3 wraps to 1 (illegal word 0x3E)
        start_run(2, 1'b1);
        mem[0] = 32'h0000_0004; mem[1] = 32'h0000_003E;
        mem[62] = 32'h0000_0102; mem[63] = 32'h1234_5678;
        push(6'b000100, {32'h0, 32'h0000_003E, 32'h0000_0004}, 0, 0, 1, 2);
        push(6'b010000, {32'h0000_0004, 32'h1234_5678, 32'h0000_0102}, 62, 62, 63, 0);
        release_rst;
        wait_end(100);
        chk("t5_final", {HALTED_, ERR_, PC_, INSTR_CNT_}, {1'b0, 1'b1, 6'd1, 32'd2});
        end_run;

        // Asynchronous reset in the middle of ISSUE
        start_run(0, 1'b0);
        mem[0] = 32'h0000_0101; mem[3] = 32'h0000_00FF;
        push(6'b100000, {32'h0, 32'h0, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        wait_issues(1, 40);
        @(posedge CLK_);
        #2 RST_ = 1'b1;
        #1 chk("t6_async_drop", {EXEC_FL_, CMD_FLGS_}, 0);
        ready_delay = 2;
        push(6'b100000, {32'h0, 32'h0, 32'h0000_0101}, 0, 0, 1, 2);
        release_rst;
        chk("t6_after_release", {INSTR_CNT_, PC_}, 0);
        wait_end(60);
        chk("t6_final", {HALTED_, ERR_, PC_, INSTR_CNT_}, {1'b1, 1'b0, 6'd3, 32'd1});
        end_run;

        chk("flags_zero_when_idle", viol, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_decoder.md
Name: fetch_decoder

Overview:
- Upstream stage of the executor: reads 3-word instructions from a synchronous program memory, decodes the opcode into the executor's one-hot command flags, and drives the 96-bit argument bus.
- Holds an issue handshake (EXEC_FL_ until READY_FL_), then advances the PC sequentially or by the executor's jump offset.
- Halts on HLT, on an illegal opcode, or on a handshake timeout.

Parameters:
- PMEM_SIZE, 64, program memory depth in 32-bit words; power of two; PC width AW = clog2(PMEM_SIZE).
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum posedges EXEC_FL_ may stay high without READY_FL_ before error.

Ports:
- CLK_  in  1  clock; all state updates on posedge.
- RST_  in  1  asynchronous active-high reset.
- PMEM_ADDR_  out  AW  program memory read address.
- PMEM_DATA_  in  32  read data; valid one cycle after the address (synchronous read).
- EXEC_FL_  out  1  command valid to executor.
- CMD_FLGS_  out  6  one-hot: [5] MOV, [4] ADD, [3] CMP, [2] JMP, [1] JEQ, [0] JGG.
- CMD_ARG_  out  96  {word2, word1, word0} of the instruction.
- READY_FL_  in  1  executor done (negedge-driven pulse).
- JMP_FL_  in  1  executor says take jump; valid when READY_FL_ is sampled high.
- NEW_EXEC_ADDR_OFF_  in  32  jump offset in words (equals word1).
- PC_  out  AW  address of the current instruction's word0.
- INSTR_CNT_  out  32  retired instruction count.
- HALTED_  out  1  HLT reached.
- ERR_  out  1  illegal opcode or timeout.

Behaviour:
- Instruction format: word0[7:0] is the opcode: 01 MOV, 02 ADD, 03 CMP, 04 JMP, 05 JEQ, 06 JGG, FF HLT; any other value is illegal. Bits word0[31:8] pass through unchanged in CMD_ARG_.
- Reset, asynchronous: state RD0, PC_=RESET_PC, EXEC_FL_=0, CMD_FLGS_=0, CMD_ARG_=0, INSTR_CNT_=0, HALTED_=0, ERR_=0, timeout counter 0.
- RD0: PMEM_ADDR_=PC. Next state RD1.
- RD1: PMEM_ADDR_=PC+1; capture word0. Next state RD2.
- RD2: PMEM_ADDR_=PC+2; capture word1. Next state RD3.
- RD3: capture word2 and decode.
  - Legal command: next state ISSUE; EXEC_FL_ and CMD_FLGS_ register high on the same edge.
  - HLT: next state HALT.
  - Illegal opcode: next state ERROR.
- Latency: EXEC_FL_ rises on the 4th posedge after reset release or after the PC update.
- ISSUE:
  - CMD_ARG_ and CMD_FLGS_ are stable for the whole state. Exactly one flag bit is set.
  - The timeout counter increments each posedge. READY_FL_ high at a posedge gives: EXEC_FL_<=0, CMD_FLGS_<=0, INSTR_CNT_++, counter cleared, next state RD0.
  - PC update on that edge: if JMP_FL_, PC <= PC + NEW_EXEC_ADDR_OFF_[AW-1:0]; otherwise PC <= PC+3.
- CMD_FLGS_ is all-zero whenever EXEC_FL_ is low. This is mandatory: the executor's write-flag logic is not gated by EXEC_FL_.
- Timeout: counter reaches TIMEOUT with no READY_FL_ → drop EXEC_FL_ and CMD_FLGS_, go to ERROR. A READY_FL_ arriving on the same edge as expiry wins: normal retire.
- HALT: HALTED_=1, EXEC_FL_=0, PMEM_ADDR_ held; sticky until reset.
- ERROR: ERR_=1, otherwise like HALT; sticky until reset.
- Address arithmetic: all PC and PC+k values are modulo PMEM_SIZE. Fetch wraps, e.g. PC=PMEM_SIZE-1 reads words 63, 0, 1. Negative jump offsets wrap two's-complement.
- Only one outstanding command at a time; no prefetch during ISSUE.
- Reset mid-ISSUE drops EXEC_FL_ immediately and asynchronously. The executor is not reset by this block, so its internal flags settle within 2 negedges, before the next issue.
- INSTR_CNT_ wraps at 2^32.

Decomposition:
- Shared package holds:
  - opcode constants (OP_MOV..OP_JGG, OP_HLT);
  - flag bit positions (FLG_MOV=5 .. FLG_JGG=0);
  - word and address width constants (32);
  - FSM state enum (RD0, RD1, RD2, RD3, ISSUE, HALT, ERROR).
- Sub-module opcode_decoder: combinational 8-bit opcode → {6-bit one-hot, is_hlt, is_illegal}; reused by bench scoreboard.

Test Plan:
- Program at 0: MOV (word0=0x0000_0101) then HLT. Executor model raises READY_FL_ 2 cycles after issue → EXEC_FL_ rises 4 posedges after reset, CMD_FLGS_=6'b100000, CMD_ARG_[31:0]=0x0000_0101; after READY, PC_=3, INSTR_CNT_=1, then HALTED_=1, PC_=3.
- JMP at PC 6 with word1=0xFFFF_FFFA, READY_FL_ and JMP_FL_ both 1 → next PC_=0 (fetch addresses 0, 1, 2); with JMP_FL_=0 (untaken JEQ) → PC_=9.
- Word0 opcode 0x07 at PC 0 → no EXEC_FL_ pulse, ERR_=1 after RD3, HALTED_=0, CMD_FLGS_=0 throughout.
- Executor never raises READY_FL_ → EXEC_FL_ high exactly TIMEOUT(15) posedges, then 0, ERR_=1. Variant with READY on the 15th edge → normal retire, ERR_=0.
- RESET_PC=62, PMEM_SIZE=64 → PMEM_ADDR_ sequence 62, 63, 0; CMD_ARG_ = {mem[0], mem[63], mem[62]}.
- Assert RST_ mid-ISSUE (asynchronously, between edges) → EXEC_FL_ and CMD_FLGS_ zero before next edge; after release, refetch from RESET_PC, INSTR_CNT_=0.
